mmio_bus: RTL and testbench
===========================

MMIO_BUS -- requirements
Module: mmio_bus

Interface
REQ-001 Parameter ADDR_W, 32, address width in bits.
REQ-002 Parameter DATA_W, 32, data width in bits (multiple of 8); BE_W = DATA_W/8.
REQ-003 Parameter N_SLV, 4, number of slave channels (1..8).
REQ-004 Parameter SLV_BASE, {N_SLV x ADDR_W'h0}, packed base address per slave; slave i occupies bits [i*ADDR_W +: ADDR_W].
REQ-005 Parameter SLV_MASK, {N_SLV x ADDR_W'h0}, packed decode mask per slave; slave i matches when (addr & mask_i) == base_i.
REQ-006 Parameter TIMEOUT, 255, cycles to wait for a slave ack before error (8-bit counter).
REQ-007 clk  in  1  system clock; all state on rising edge.
REQ-008 RST  in  1  reset; asynchronous, active-high.
REQ-009 m_req  in  1  master request; held until m_ack.
REQ-010 m_we  in  1  1 = write, 0 = read.
REQ-011 m_be  in  BE_W  byte enables.
REQ-012 m_addr  in  ADDR_W  request address.
REQ-013 m_wdata  in  DATA_W  write data.
REQ-014 m_rdata  out  DATA_W  read data, valid while m_ack = 1.
REQ-015 m_ack  out  1  one-cycle completion pulse.
REQ-016 m_err  out  1  error flag, valid with m_ack (decode miss or timeout).
REQ-017 s_req  out  N_SLV  one-hot slave request.
REQ-018 s_we, s_be, s_addr, s_wdata  out  1/BE_W/ADDR_W/DATA_W  broadcast copies of latched request.
REQ-019 s_rdata  in  N_SLV*DATA_W  packed slave read data.
REQ-020 s_ack  in  N_SLV  per-slave completion.

Function
REQ-021 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-022 IDLE: on m_req = 1, latch m_we/m_be/m_addr/m_wdata and decode; match -> WAIT with s_req one-hot on next cycle; no match -> RESP with err = 1.
REQ-023 Lowest-index matching slave wins on overlapping regions.
REQ-024 WAIT: s_req[sel] held high; s_ack[sel] = 1 -> capture s_rdata[sel], err = 0, go to RESP; s_req drops the same edge.
REQ-025 WAIT: s_ack on non-selected slaves ignored.
REQ-026 RESP: m_ack = 1 for exactly one cycle, m_rdata = captured data (0 on error or write), m_err = err; then IDLE.
REQ-027 Minimum latency m_req -> m_ack: 3 cycles for 0-wait slave; 2 cycles for decode miss.
REQ-028 New request accepted only in IDLE; back-to-back requests serviced with one IDLE cycle between.
REQ-029 m_rdata and m_err hold last values outside RESP; m_ack low.

Reset
REQ-030 RST asserted at any time: state IDLE, s_req = 0, m_ack = 0, m_err = 0, m_rdata = 0, latched request = 0, timeout counter = 0, asynchronously; an in-flight transaction is dropped without ack.

Configuration
REQ-031 Macro MMIO_BUS_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle; reaching TIMEOUT without ack -> s_req = 0, RESP with err = 1, m_rdata = 0.
REQ-032 Macro undefined: no counter logic; WAIT persists until s_ack[sel] or reset.

Structure
REQ-033 Shared package/include soc_bus_pkg holds FSM state encodings and default parameter values.
REQ-034 Sub-module mmio_decode: combinational address -> one-hot select plus hit flag, parameterised by N_SLV/SLV_BASE/SLV_MASK.

Verification
REQ-035 N_SLV=4, slave1 base 0x1000 mask 0xF000, read 0x1004, slave acks after 2 cycles with 0xDEADBEEF -> s_req=4'b0010, m_ack pulse, m_rdata 0xDEADBEEF, m_err 0.
REQ-036 Write 0x1008 data 0x12345678 be 4'b0011 -> s_we=1, s_be=4'b0011, s_wdata=0x12345678, single m_ack, m_err 0.
REQ-037 Read 0xF000 (no region) -> no s_req, m_ack at cycle 2 with m_err 1, m_rdata 0.
REQ-038 MMIO_BUS_TIMEOUT_EN, TIMEOUT=8, slave never acks -> s_req drops after 8 WAIT cycles, m_ack with m_err 1; without macro, m_ack never asserts for 50 cycles.
REQ-039 RST pulsed during WAIT -> s_req, m_ack 0 immediately; subsequent read to slave0 completes normally.
REQ-040 Overlapping regions slave0/slave2 both match 0x2000 -> s_req=4'b0001.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared FSM state encoding and default bus parameters
package soc_bus_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_N_SLV   = 4;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: address to one-hot slave select, lowest matching index wins
module mmio_decode #(
  parameter int                        ADDR_W   = 32,
  parameter int                        N_SLV    = 4,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [N_SLV-1:0]  o_sel,
  output logic              o_hit
);
  // scan high to low so the lowest matching region overwrites the rest
  always_comb begin
    o_sel = '0;
    for (int i = N_SLV - 1; i >= 0; i--)
      if ((i_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
      end
    o_hit = |o_sel;
  end
endmodule

// File: rtl/mmio_bus.sv
// mmio_bus: single-master MMIO interconnect with address decode; MMIO_BUS_TIMEOUT_EN enables the slave ack timeout
module mmio_bus import soc_bus_pkg::*; #(
  parameter int                        ADDR_W   = DEF_ADDR_W,
  parameter int                        DATA_W   = DEF_DATA_W,
  parameter int                        N_SLV    = DEF_N_SLV,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0,
  parameter int                        TIMEOUT  = DEF_TIMEOUT,
  localparam int                       BE_W     = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    m_req,
  input  logic                    m_we,
  input  logic [BE_W-1:0]         m_be,
  input  logic [ADDR_W-1:0]       m_addr,
  input  logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_ack,
  output logic                    m_err,
  output logic [N_SLV-1:0]        s_req,
  output logic                    s_we,
  output logic [BE_W-1:0]         s_be,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
  input  logic [N_SLV-1:0]        s_ack
);
  state_t              r_state, w_next;
  logic                r_we, r_err;
  logic [BE_W-1:0]     r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata, w_rdata;
  logic [N_SLV-1:0]    r_sel, w_sel;
  logic                w_hit, w_ack, w_tmo, w_accept;
  mmio_decode #(
    .ADDR_W  (ADDR_W),
    .N_SLV   (N_SLV),
    .SLV_BASE(SLV_BASE),
    .SLV_MASK(SLV_MASK)
  ) u_decode (
    .i_addr(m_addr),
    .o_sel (w_sel),
    .o_hit (w_hit)
  );
`ifdef MMIO_BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_cnt;
  // count WAIT cycles; zero whenever outside WAIT so entry starts from zero
  always_ff @(posedge clk or posedge RST)
    if (RST) r_cnt <= '0;
    else     r_cnt <= (r_state == ST_WAIT) ? r_cnt + 8'd1 : '0;
  assign w_tmo = (r_state == ST_WAIT) && (r_cnt == TMO_LAST);
`else
  assign w_tmo = 1'b0;
`endif
  assign w_accept = (r_state == ST_IDLE) && m_req;
  assign w_ack    = |(s_ack & r_sel);
  // select the read data of the addressed slave only
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N_SLV; i++)
      w_rdata = w_rdata | (r_sel[i] ? s_rdata[i*DATA_W +: DATA_W] : '0);
  end
  // next-state logic
  always_comb begin
    w_next = r_state;
    w_next = (r_state == ST_IDLE) ? (m_req ? (w_hit ? ST_WAIT : ST_RESP) : ST_IDLE) :
             (r_state == ST_WAIT) ? ((w_ack || w_tmo) ? ST_RESP : ST_WAIT) : ST_IDLE;
  end
  // state register, request latch and response capture
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= m_we;
        r_be    <= m_be;
        r_addr  <= m_addr;
        r_wdata <= m_wdata;
        r_sel   <= w_sel;
        if (!w_hit) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == ST_WAIT && w_ack) begin
        r_rdata <= r_we ? '0 : w_rdata;
        r_err   <= 1'b0;
      end else if (w_tmo) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  assign s_req   = (r_state == ST_WAIT) ? r_sel : '0;
  assign s_we    = r_we;
  assign s_be    = r_be;
  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;
  assign m_ack   = (r_state == ST_RESP);
  assign m_rdata = r_rdata;
  assign m_err   = r_err;
endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: randomized self-checking bench for mmio_bus against a transaction-level model
module tb_mmio_bus;
  localparam logic [127:0] BASES = {32'h0000_8000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
  localparam logic [127:0] MASKS = {32'h0000_C000, 32'h0000_E000, 32'h0000_F000, 32'h0000_F000};
  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic         m_req = 1'b0, m_we = 1'b0;
  logic [3:0]   m_be = '0;
  logic [31:0]  m_addr = '0, m_wdata = '0;
  logic [31:0]  m_rdata;
  logic         m_ack, m_err;
  logic [3:0]   s_req;
  logic         s_we;
  logic [3:0]   s_be;
  logic [31:0]  s_addr, s_wdata;
  logic [127:0] s_rdata = '0;
  logic [3:0]   s_ack = '0;
  int           n_chk = 0, n_err = 0;
  logic [31:0]  base_tab [4] = '{32'h2000, 32'h1000, 32'h2000, 32'h8000};
  logic [31:0]  mask_tab [4] = '{32'hF000, 32'hF000, 32'hE000, 32'hC000};
  mmio_bus #(
    .ADDR_W(32), .DATA_W(32), .N_SLV(4),
    .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT(8)
  ) dut (
    .clk(clk), .RST(RST),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int ref_sel(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & mask_tab[i]) == base_tab[i]) return i;
    return -1;
  endfunction
  task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly, input logic noise);
    int          sel;
    logic [3:0]  exp_req;
    logic [31:0] exp_rd;
    logic        exp_err;
    sel = ref_sel(addr);
    m_req = 1'b1; m_we = we; m_be = be; m_addr = addr; m_wdata = wd; s_ack = '0;
    @(posedge clk); #1;
    m_we = ~we; m_be = ~be; m_addr = $urandom; m_wdata = $urandom;
    if (sel < 0) begin
      exp_rd = '0; exp_err = 1'b1;
      check("miss_sreq", s_req, 4'b0);
      check("miss_ack", m_ack, 1'b1);
      check("miss_err", m_err, 1'b1);
      check("miss_rdata", m_rdata, 32'h0);
    end else begin
      exp_req = 4'b1 << sel;
      exp_rd  = we ? 32'h0 : rd;
      exp_err = 1'b0;
      check("sreq", s_req, exp_req);
      check("s_we", s_we, we);
      check("s_be", s_be, be);
      check("s_addr", s_addr, addr);
      check("s_wdata", s_wdata, wd);
      for (int k = 0; k <= dly; k++) begin
        s_ack   = noise ? (4'($urandom) & ~exp_req) : 4'b0;
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (k == dly) begin
          s_ack = s_ack | exp_req;
          s_rdata[sel*32 +: 32] = rd;
        end
        @(posedge clk); #1;
        if (k < dly) begin
          check("wait_ack", m_ack, 1'b0);
          check("wait_sreq", s_req, exp_req);
        end
      end
      s_ack = '0;
      check("ack", m_ack, 1'b1);
      check("err", m_err, 1'b0);
      check("rdata", m_rdata, exp_rd);
      check("sreq_drop", s_req, 4'b0);
    end
    m_req = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", m_ack, 1'b0);
    check("hold_rdata", m_rdata, exp_rd);
    check("hold_err", m_err, exp_err);
  endtask
  initial begin
    int acks;
    #1;
    check("rst_ack", m_ack, 1'b0);
    check("rst_err", m_err, 1'b0);
    check("rst_rdata", m_rdata, 32'h0);
    check("rst_sreq", s_req, 4'b0);
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    do_txn(1'b0, 4'hF, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
    do_txn(1'b1, 4'b0011, 32'h0000_1008, 32'h1234_5678, 32'hCAFE_F00D, 0, 1'b0);
    do_txn(1'b0, 4'hF, 32'h0000_F000, 32'h0, 32'h1111_2222, 0, 1'b0);
    do_txn(1'b0, 4'hF, 32'h0000_2000, 32'h0, 32'hA5A5_0001, 1, 1'b1);
    do_txn(1'b0, 4'hF, 32'h0000_3000, 32'h0, 32'hA5A5_0002, 0, 1'b1);
    do_txn(1'b0, 4'hF, 32'h0000_9ABC, 32'h0, 32'h0BAD_CAFE, 3, 1'b1);
    for (int t = 0; t < 40; t++)
      do_txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom));
    m_req = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = 32'h0000_8000; s_ack = '0;
    @(posedge clk); #1;
    check("to_sreq", s_req, 4'b1000);
`ifdef MMIO_BUS_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      check("to_wait_ack", m_ack, 1'b0);
      check("to_wait_sreq", s_req, 4'b1000);
    end
    @(posedge clk); #1;
    check("to_ack", m_ack, 1'b1);
    check("to_err", m_err, 1'b1);
    check("to_rdata", m_rdata, 32'h0);
    check("to_sreq_drop", s_req, 4'b0);
    m_req = 1'b0;
    @(posedge clk); #1;
`else
    acks = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (m_ack) acks++;
    end
    check("no_ack_50", acks, 0);
    check("still_sreq", s_req, 4'b1000);
    m_req = 1'b0;
    #3 RST = 1'b1;
    #1;
    check("async_rst_sreq", s_req, 4'b0);
    check("async_rst_ack", m_ack, 1'b0);
    #2 RST = 1'b0;
`endif
    do_txn(1'b0, 4'hF, 32'h0000_2010, 32'h0, 32'h5555_AAAA, 0, 1'b0);
    m_req = 1'b1; m_we = 1'b1; m_be = 4'h3; m_addr = 32'h0000_2020; m_wdata = 32'h7777_0000;
    @(posedge clk); #1;
    check("pre_rst_sreq", s_req, 4'b0001);
    @(posedge clk); #1;
    #3 RST = 1'b1;
    #1;
    check("rst_wait_sreq", s_req, 4'b0);
    check("rst_wait_ack", m_ack, 1'b0);
    check("rst_wait_err", m_err, 1'b0);
    check("rst_wait_rdata", m_rdata, 32'h0);
    check("rst_wait_addr", s_addr, 32'h0);
    m_req = 1'b0;
    @(posedge clk); #1;
    RST = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ack", m_ack, 1'b0);
    do_txn(1'b0, 4'hF, 32'h0000_2044, 32'h0, 32'h0123_4567, 1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
